// File: rtl/mod_dp.sv
// mod_dp -- datapath for an iterative unsigned modulo (repeated subtraction).
//
// The controller issues ld_temp to latch a dividend/divisor pair, then sub
// pulses while comp is high. Each accepted sub removes one divisor from the
// running remainder. Once no further subtraction is legal after a load,
// result_valid rises and stays high until the next load or reset.
//
// Optional feature: define MOD_QUOTIENT_EN to add the quotient register/port.
//
// Ports:
//   clk           in   clock, all state changes on the rising edge
//   reset         in   synchronous active-high reset (priority over commands)
//   a             in   WIDTH  dividend, sampled on ld_temp
//   b             in   WIDTH  divisor, sampled on ld_temp
//   ld_temp       in   load command (wins over sub)
//   sub           in   subtract-step command
//   comp          out  combinational: divr != 0 and temp >= divr
//   result        out  WIDTH  running remainder (temp register, no extra stage)
//   div_zero      out  latched divisor is zero
//   result_valid  out  remainder is final for the current load
//   quotient      out  WIDTH  subtraction count (MOD_QUOTIENT_EN only)
module mod_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ld_temp,
  input  logic             sub,
  output logic             comp,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             result_valid
`ifdef MOD_QUOTIENT_EN
  ,
  output logic [WIDTH-1:0] quotient
`endif
);

  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] divr_q, divr_d;
  logic             div_zero_q, div_zero_d;
  logic             valid_q, valid_d;
  // Remembers that a load happened since reset, so result_valid cannot
  // rise from the idle post-reset state where comp is trivially 0.
  logic             armed_q, armed_d;
`ifdef MOD_QUOTIENT_EN
  logic [WIDTH-1:0] quot_q, quot_d;
`endif

  // Checking divr != 0 also makes a zero divisor never subtractable.
  assign comp = (divr_q != '0) && (temp_q >= divr_q);

  always_comb begin
    temp_d     = temp_q;
    divr_d     = divr_q;
    div_zero_d = div_zero_q;
    valid_d    = valid_q;
    armed_d    = armed_q;
`ifdef MOD_QUOTIENT_EN
    quot_d     = quot_q;
`endif
    if (ld_temp) begin
      temp_d     = a;
      divr_d     = b;
      div_zero_d = (b == '0);
      valid_d    = 1'b0;
      armed_d    = 1'b1;
`ifdef MOD_QUOTIENT_EN
      quot_d     = '0;
`endif
    end else begin
      if (sub && comp) begin
        temp_d = temp_q - divr_q;
`ifdef MOD_QUOTIENT_EN
        quot_d = quot_q + 1'b1;
`endif
      end
      if (armed_q && !comp) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q     <= '0;
      divr_q     <= '0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
      armed_q    <= 1'b0;
`ifdef MOD_QUOTIENT_EN
      quot_q     <= '0;
`endif
    end else begin
      temp_q     <= temp_d;
      divr_q     <= divr_d;
      div_zero_q <= div_zero_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
`ifdef MOD_QUOTIENT_EN
      quot_q     <= quot_d;
`endif
    end
  end

  assign result       = temp_q;
  assign div_zero     = div_zero_q;
  assign result_valid = valid_q;
`ifdef MOD_QUOTIENT_EN
  assign quotient     = quot_q;
`endif

endmodule

// File: tb/tb_mod_dp.sv
// tb_mod_dp -- directed bench for mod_dp with a per-cycle reference model.
// The model keeps the loaded operands and the number of accepted subtractions,
// and derives remainder/comp from integer division of those operands.
module tb_mod_dp;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, ld_temp, sub;
  logic [W-1:0] a, b;
  logic         comp, div_zero, result_valid;
  logic [W-1:0] result;
`ifdef MOD_QUOTIENT_EN
  logic [W-1:0] quotient;
`endif

  int checks = 0;
  int failures = 0;

  mod_dp #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .ld_temp      (ld_temp),
    .sub          (sub),
    .comp         (comp),
    .result       (result),
    .div_zero     (div_zero),
    .result_valid (result_valid)
`ifdef MOD_QUOTIENT_EN
    ,
    .quotient     (quotient)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint unsigned m_a = 0, m_b = 0, m_k = 0;
  bit m_loaded = 0, m_rv = 0, m_ok = 0;

  function automatic bit mdl_comp();
    if (m_b == 0) return 1'b0;
    return m_k < (m_a / m_b);
  endfunction

  function automatic longint unsigned mdl_rem();
    return m_a - m_k * m_b;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_a <= 0; m_b <= 0; m_k <= 0;
      m_loaded <= 0; m_rv <= 0; m_ok <= 1;
    end else if (ld_temp) begin
      m_a <= a; m_b <= b; m_k <= 0;
      m_loaded <= 1; m_rv <= 0;
    end else begin
      if (sub && mdl_comp()) m_k <= m_k + 1;
      if (m_loaded && !mdl_comp()) m_rv <= 1;
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_result", result, mdl_rem());
      chk("m_comp", comp, mdl_comp());
      chk("m_div_zero", div_zero, m_loaded && (m_b == 0));
      chk("m_result_valid", result_valid, m_rv);
`ifdef MOD_QUOTIENT_EN
      chk("m_quotient", quotient, m_k);
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Inputs are driven at the negedge; the following posedge samples them.
  task automatic step(input bit r, input bit l, input bit s,
                      input logic [W-1:0] aa, input logic [W-1:0] bb);
    reset = r; ld_temp = l; sub = s; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold sub until comp drops (bounded); returns number of sub edges applied.
  task automatic run_subs(input int max, output int n);
    n = 0;
    while (comp && n < max) begin
      step(0, 0, 1, '0, '0);
      n++;
    end
    if (comp) begin
      failures++;
      checks++;
      $display("FAIL sub_timeout: comp still %0d after %0d subs, required 0", comp, n);
    end
  endtask

  int n;

  initial begin
    reset = 1; ld_temp = 0; sub = 0; a = '0; b = '0;
    @(negedge clk);
    step(1, 0, 0, '0, '0);
    chk("rst_result", result, 0);
    chk("rst_comp", comp, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_rv", result_valid, 0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    chk("idle_rv", result_valid, 0);

    // 17 mod 5
    step(0, 1, 0, 17, 5);
    chk("l17_comp", comp, 1);
    chk("l17_result", result, 17);
    run_subs(50, n);
    chk("l17_nsubs", n, 3);
    chk("l17_result_end", result, 2);
    chk("l17_rv_pre", result_valid, 0);
`ifdef MOD_QUOTIENT_EN
    chk("l17_quot", quotient, 3);
`endif
    step(0, 0, 1, '0, '0);
    chk("l17_rv", result_valid, 1);
    chk("l17_hold", result, 2);
    step(0, 0, 0, '0, '0);

    // divide by zero
    step(0, 1, 0, 9, 0);
    chk("dz_comp", comp, 0);
    chk("dz_flag", div_zero, 1);
    chk("dz_result", result, 9);
    step(0, 0, 1, '0, '0);
    chk("dz_rv", result_valid, 1);
    step(0, 0, 1, '0, '0);
    step(0, 0, 1, '0, '0);
    chk("dz_result_after", result, 9);

    // a < b
    step(0, 1, 0, 3, 7);
    chk("lt_comp", comp, 0);
    chk("lt_dz", div_zero, 0);
    step(0, 0, 1, '0, '0);
    chk("lt_result", result, 3);
    chk("lt_rv", result_valid, 1);
`ifdef MOD_QUOTIENT_EN
    chk("lt_quot", quotient, 0);
`endif

    // abort mid-operation, then reload
    step(0, 1, 0, 100, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 1, '0, '0);
    chk("ab_mid", result, 60);
    step(1, 0, 1, '0, '0);
    chk("ab_result", result, 0);
    chk("ab_comp", comp, 0);
    chk("ab_rv", result_valid, 0);
    chk("ab_dz", div_zero, 0);
    step(0, 1, 0, 20, 6);
    run_subs(50, n);
    chk("rl_nsubs", n, 3);
    chk("rl_result", result, 2);

    // load wins over sub
    step(0, 1, 1, 50, 8);
    chk("lw_result", result, 50);
`ifdef MOD_QUOTIENT_EN
    chk("lw_quot", quotient, 0);
`endif
    run_subs(50, n);
    chk("lw_nsubs", n, 6);
    chk("lw_result_end", result, 2);
`ifdef MOD_QUOTIENT_EN
    chk("lw_quot_end", quotient, 6);
`endif

    // a == b and a == 0
    step(0, 1, 0, 8, 8);
    run_subs(10, n);
    chk("eq_nsubs", n, 1);
    chk("eq_result", result, 0);
    step(0, 1, 0, 0, 5);
    chk("zero_comp", comp, 0);

    // large operands near the top of the range
    step(0, 1, 0, 32'hFFFF_FFFF, 32'h8000_0000);
    run_subs(10, n);
    chk("big_nsubs", n, 1);
    chk("big_result", result, 32'h7FFF_FFFF);

    // reset beats a simultaneous load
    step(1, 1, 1, 77, 3);
    chk("rp_result", result, 0);
    chk("rp_comp", comp, 0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_dp.md
MOD_DP -- requirements
Module: mod_dp

Interface
REQ-001 Parameter WIDTH, default 32, operand, remainder and quotient width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 a  input  WIDTH  unsigned dividend; sampled only when ld_temp=1.
REQ-005 b  input  WIDTH  unsigned divisor; sampled only when ld_temp=1.
REQ-006 ld_temp  input  1  load command from the mod controller.
REQ-007 sub  input  1  subtract-step command from the mod controller.
REQ-008 comp  output  1  combinational status to the controller: another subtraction is legal.
REQ-009 result  output  WIDTH  registered running remainder (temp register).
REQ-010 div_zero  output  1  registered flag: the latched divisor is zero.
REQ-011 result_valid  output  1  registered flag: the remainder is final for the current load.
REQ-012 quotient  output  WIDTH  registered subtraction count; present only under MOD_QUOTIENT_EN.

Function
REQ-013 Internal registers: temp (WIDTH), divr (WIDTH), div_zero, result_valid, and quotient when MOD_QUOTIENT_EN is defined.
REQ-014 comp SHALL be (divr != 0) AND (temp >= divr), unsigned compare, purely combinational, with no registered delay.
REQ-015 ld_temp=1: next edge SHALL set temp<=a, divr<=b, div_zero<=(b==0), result_valid<=0, quotient<=0.
REQ-016 sub=1 and comp=1 and ld_temp=0: next edge SHALL set temp<=temp-divr and quotient<=quotient+1.
REQ-017 sub=1 with comp=0: temp, divr and quotient SHALL hold; the step SHALL be ignored and no underflow SHALL occur.
REQ-018 ld_temp and sub both asserted: ld_temp SHALL win; no subtraction is applied that cycle.
REQ-019 result_valid SHALL set on the first edge after a load where ld_temp=0 and comp=0, and SHALL hold until the next ld_temp or reset.
REQ-020 Divide by zero: comp SHALL stay 0, result SHALL remain equal to a, div_zero=1, result_valid=1 one cycle after the load.
REQ-021 a<b: comp=0 immediately after the load, result=a, quotient=0, result_valid=1 one cycle later.
REQ-022 Latency: a load with a>=b>0 SHALL need exactly floor(a/b) sub cycles until comp=0; the remainder equals a mod b.
REQ-023 Quotient cannot overflow, since quotient<=a; no saturation logic is required.
REQ-024 With no command asserted, all registers SHALL hold.
REQ-025 result SHALL reflect temp directly, with no additional output register stage.

Reset
REQ-026 reset=1 at an edge SHALL clear temp, divr, quotient, div_zero and result_valid to 0, giving comp=0.
REQ-027 reset SHALL take priority over ld_temp and sub in the same cycle.
REQ-028 reset asserted mid-operation SHALL abort the operation; no partial result is retained and result_valid=0.
REQ-029 Before the first load after reset, div_zero SHALL read 0 even though divr=0.

Configuration
REQ-030 Macro MOD_QUOTIENT_EN defined: the quotient port and register SHALL exist and behave per REQ-015/016.
REQ-031 Macro MOD_QUOTIENT_EN undefined: the quotient port and register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 a=17, b=5, ld_temp 1 cycle, then sub held -> comp=1 for 3 sub cycles, then result=2, quotient=3, comp=0, result_valid=1 next edge.
REQ-033 a=9, b=0, ld_temp -> comp=0, div_zero=1, result=9, result_valid=1; sub pulses leave result=9.
REQ-034 a=3, b=7, ld_temp then sub=1 -> result=3, quotient=0, comp=0, no change on sub.
REQ-035 a=100, b=1 load; reset after 40 subs -> all outputs 0; reload a=20, b=6 -> result=2, quotient=3.
REQ-036 ld_temp and sub both asserted with a=50, b=8 -> temp=50, quotient=0 (load wins); 6 subs later result=2, quotient=6.
REQ-037 Build without MOD_QUOTIENT_EN, repeat REQ-032 -> result=2, comp/result_valid timing unchanged, no quotient port.
